cache_mem_arbiter: RTL and testbench

- Arbitrates the single-ported RAM between the instruction cache and the data cache.
- Sits between both caches and the RAM model, with registered grant selection.
- The grant is held until RAM completes the access; the data cache has priority.
- A consecutive-grant limit bounds instruction-fetch starvation during long dirty-block flushes.

---
 rtl/cache_mem_arbiter_if.sv | 34 +++
 rtl/cache_mem_arbiter.sv | 129 ++++++++++++
 tb/tb_cache_mem_arbiter.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_mem_arbiter_if.sv
// Bundle of icache, dcache and RAM-side signals around the cache/RAM arbiter.
// master is the arbiter's view; slave is the view of the caches and the RAM model.
interface cache_mem_arbiter_if;
    logic        iREN;
    logic [31:0] iaddr;
    logic [31:0] iload;
    logic        iwait;

    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic [31:0] dload;
    logic        dwait;

    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;
    logic [1:0]  ramstate;

    logic        err;

    modport master (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        output iload, iwait, dload, dwait, ramREN, ramWEN, ramaddr, ramstore, err
    );

    modport slave (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        input  iload, iwait, dload, dwait, ramREN, ramWEN, ramaddr, ramstore, err
    );
endinterface

// File: rtl/cache_mem_arbiter.sv
// Shares one single-ported RAM between icache and dcache; dcache has priority, grant held to completion.
// Define CACHE_ARB_FAIRNESS_EN to cap consecutive dcache grants (MAXD) while an ifetch is pending.
module cache_mem_arbiter #(
    parameter int MAXD = 4
) (
    input  logic                CLK,
    input  logic                nRST,
    cache_mem_arbiter_if.master bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DGRANT = 2'd1,
        IGRANT = 2'd2
    } state_t;

    localparam logic [1:0] RAM_ACCESS = 2'b10;
    localparam logic [1:0] RAM_ERROR  = 2'b11;

    state_t      state_q, state_d;
    logic        err_q, err_d;
    logic        d_req;
    logic        limit_hit;
    logic        ram_ok;
    logic        ram_bad;
    logic        ram_ren;
    logic        ram_wen;
    logic [31:0] ram_addr;
    logic [31:0] ram_store;
    logic        i_wait;
    logic        d_wait;

    if (MAXD < 1) begin : g_maxd_check
        $error("cache_mem_arbiter: MAXD must be at least 1");
    end

    assign d_req   = bus.dREN | bus.dWEN;
    assign ram_ok  = (bus.ramstate == RAM_ACCESS);
    assign ram_bad = (bus.ramstate == RAM_ERROR);

`ifdef CACHE_ARB_FAIRNESS_EN
    localparam int              CNT_W   = $clog2(MAXD + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAXD);

    logic [CNT_W-1:0] dcnt_q, dcnt_d;

    assign limit_hit = bus.iREN && (dcnt_q == CNT_MAX);

    // Counts dcache completions that happened while an ifetch was waiting.
    always_comb begin
        dcnt_d = dcnt_q;
        case (state_q)
            IDLE: begin
                if (!bus.iREN) dcnt_d = '0;
            end
            DGRANT: begin
                if (d_req && ram_ok && bus.iREN && (dcnt_q != CNT_MAX))
                    dcnt_d = dcnt_q + CNT_W'(1);
            end
            IGRANT: begin
                if (bus.iREN && ram_ok) dcnt_d = '0;
            end
            default: dcnt_d = '0;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) dcnt_q <= '0;
        else       dcnt_q <= dcnt_d;
    end
`else
    assign limit_hit = 1'b0;
`endif

    // RAM side follows the granted requester combinationally so a RAM answer
    // in the same cycle completes the access without an extra stage.
    always_comb begin
        state_d   = state_q;
        err_d     = err_q;
        ram_ren   = 1'b0;
        ram_wen   = 1'b0;
        ram_addr  = '0;
        ram_store = '0;
        i_wait    = 1'b1;
        d_wait    = 1'b1;
        case (state_q)
            IDLE: begin
                if (d_req && !limit_hit) state_d = DGRANT;
                else if (bus.iREN)       state_d = IGRANT;
            end
            DGRANT: begin
                ram_addr  = bus.daddr;
                ram_store = bus.dstore;
                ram_wen   = bus.dWEN;
                ram_ren   = bus.dREN & ~bus.dWEN;
                d_wait    = ~(d_req & ram_ok);
                if (ram_bad) err_d = 1'b1;
                if (!d_req || ram_ok || ram_bad) state_d = IDLE;
            end
            IGRANT: begin
                ram_addr = bus.iaddr;
                ram_ren  = bus.iREN;
                i_wait   = ~(bus.iREN & ram_ok);
                if (ram_bad) err_d = 1'b1;
                if (!bus.iREN || ram_ok || ram_bad) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= IDLE;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
        end
    end

    assign bus.ramREN   = ram_ren;
    assign bus.ramWEN   = ram_wen;
    assign bus.ramaddr  = ram_addr;
    assign bus.ramstore = ram_store;
    assign bus.iwait    = i_wait;
    assign bus.dwait    = d_wait;
    assign bus.iload    = bus.ramload;
    assign bus.dload    = bus.ramload;
    assign bus.err      = err_q;
endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Bench for cache_mem_arbiter: directed scenarios plus randomized cache/RAM traffic against a
// transaction-level reference model; honours CACHE_ARB_FAIRNESS_EN the same way as the design.
module tb_cache_mem_arbiter;
    localparam int MAXD = 4;
    localparam logic [1:0] RS_FREE   = 2'b00;
    localparam logic [1:0] RS_BUSY   = 2'b01;
    localparam logic [1:0] RS_ACCESS = 2'b10;
    localparam logic [1:0] RS_ERROR  = 2'b11;
    localparam int OWN_NONE = 0;
    localparam int OWN_D    = 1;
    localparam int OWN_I    = 2;

`ifdef CACHE_ARB_FAIRNESS_EN
    localparam bit FAIR = 1'b1;
`else
    localparam bit FAIR = 1'b0;
`endif

    logic CLK  = 1'b0;
    logic nRST = 1'b0;

    cache_mem_arbiter_if bus ();

    cache_mem_arbiter #(.MAXD(MAXD)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_errors = 0;

    // reference model: who owns the RAM, dcache wins since last ifetch, sticky error
    int m_own    = OWN_NONE;
    int m_streak = 0;
    bit m_err    = 1'b0;
    logic exp_iwait = 1'b1;
    logic exp_dwait = 1'b1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_own    = OWN_NONE;
        m_streak = 0;
        m_err    = 1'b0;
    endtask

    // Called just after a falling edge: settle, predict every output, compare.
    task automatic probe();
        logic        e_ren, e_wen;
        logic [31:0] e_addr, e_store;
        #1;
        e_ren = 1'b0; e_wen = 1'b0; e_addr = '0; e_store = '0;
        exp_iwait = 1'b1;
        exp_dwait = 1'b1;
        if (m_own == OWN_D) begin
            e_addr  = bus.daddr;
            e_store = bus.dstore;
            e_wen   = bus.dWEN;
            e_ren   = bus.dREN & ~bus.dWEN;
            if ((bus.dREN | bus.dWEN) && bus.ramstate == RS_ACCESS) exp_dwait = 1'b0;
        end else if (m_own == OWN_I) begin
            e_addr = bus.iaddr;
            e_ren  = bus.iREN;
            if (bus.iREN && bus.ramstate == RS_ACCESS) exp_iwait = 1'b0;
        end
        check_eq("ramREN",   32'(bus.ramREN), 32'(e_ren));
        check_eq("ramWEN",   32'(bus.ramWEN), 32'(e_wen));
        check_eq("ramaddr",  bus.ramaddr,     e_addr);
        check_eq("ramstore", bus.ramstore,    e_store);
        check_eq("iwait",    32'(bus.iwait),  32'(exp_iwait));
        check_eq("dwait",    32'(bus.dwait),  32'(exp_dwait));
        check_eq("iload",    bus.iload,       bus.ramload);
        check_eq("dload",    bus.dload,       bus.ramload);
        check_eq("err",      32'(bus.err),    32'(m_err));
    endtask

    // Advance the model by one clock using the inputs of the current cycle.
    task automatic tick();
        int own_n, streak_n;
        bit err_n, d_req, i_req, ok, bad, starve, req;
        own_n    = m_own;
        streak_n = m_streak;
        err_n    = m_err;
        d_req    = bus.dREN | bus.dWEN;
        i_req    = bus.iREN;
        ok       = (bus.ramstate == RS_ACCESS);
        bad      = (bus.ramstate == RS_ERROR);
        starve   = 1'b0;
        if (m_own == OWN_NONE) begin
            if (FAIR) begin
                starve = i_req && (m_streak >= MAXD);
                if (!i_req) streak_n = 0;
            end
            if (d_req && !starve) own_n = OWN_D;
            else if (i_req)       own_n = OWN_I;
        end else begin
            req = (m_own == OWN_D) ? d_req : i_req;
            if (bad) err_n = 1'b1;
            if (!req) begin
                own_n = OWN_NONE;
            end else if (bad) begin
                own_n = OWN_NONE;
                $display("txn %s error addr=%h (retry)", (m_own == OWN_D) ? "dcache" : "icache",
                         bus.ramaddr);
            end else if (ok) begin
                own_n = OWN_NONE;
                if (m_own == OWN_D) begin
                    if (i_req) streak_n = (m_streak < MAXD) ? m_streak + 1 : MAXD;
                    $display("txn dcache %s addr=%h data=%h", bus.dWEN ? "write" : "read",
                             bus.daddr, bus.dWEN ? bus.dstore : bus.ramload);
                end else begin
                    streak_n = 0;
                    $display("txn icache read addr=%h data=%h", bus.iaddr, bus.ramload);
                end
            end
        end
        @(posedge CLK);
        m_own    = own_n;
        m_streak = streak_n;
        m_err    = err_n;
        @(negedge CLK);
    endtask

    task automatic idle(input int n);
        bus.iREN = 1'b0; bus.dREN = 1'b0; bus.dWEN = 1'b0;
        bus.ramstate = RS_FREE;
        for (int i = 0; i < n; i++) begin
            probe();
            tick();
        end
    endtask

    function automatic logic [1:0] pick_ramstate();
        int r;
        r = $urandom_range(99);
        if (r < 35) return RS_ACCESS;
        if (r < 70) return RS_BUSY;
        if (r < 85) return RS_FREE;
        return RS_ERROR;
    endfunction

    initial begin
        logic [31:0] exp_addr;
        int ops;

        bus.iREN = 1'b0; bus.iaddr = '0;
        bus.dREN = 1'b1; bus.dWEN = 1'b0; bus.daddr = 32'h55; bus.dstore = 32'h1;
        bus.ramload = 32'h0; bus.ramstate = RS_ACCESS;

        // reset held with a request present: outputs must stay idle
        @(negedge CLK);
        #1;
        check_eq("rst_ramREN",   32'(bus.ramREN), 32'd0);
        check_eq("rst_ramWEN",   32'(bus.ramWEN), 32'd0);
        check_eq("rst_ramaddr",  bus.ramaddr,     32'd0);
        check_eq("rst_ramstore", bus.ramstore,    32'd0);
        check_eq("rst_iwait",    32'(bus.iwait),  32'd1);
        check_eq("rst_dwait",    32'(bus.dwait),  32'd1);
        check_eq("rst_err",      32'(bus.err),    32'd0);
        bus.dREN = 1'b0;
        nRST = 1'b1;
        @(negedge CLK);
        idle(2);
        check_eq("post_rst_ramREN", 32'(bus.ramREN), 32'd0);
        check_eq("post_rst_iwait",  32'(bus.iwait),  32'd1);

        // icache alone, two BUSY cycles before ACCESS
        bus.iREN = 1'b1; bus.iaddr = 32'h40; bus.ramstate = RS_FREE;
        probe(); check_eq("i_c0_ren", 32'(bus.ramREN), 32'd0); tick();
        bus.ramstate = RS_BUSY;
        probe(); check_eq("i_c1_ren", 32'(bus.ramREN), 32'd1);
        check_eq("i_c1_addr", bus.ramaddr, 32'h40);
        check_eq("i_c1_iwait", 32'(bus.iwait), 32'd1); tick();
        probe(); check_eq("i_c2_ren", 32'(bus.ramREN), 32'd1);
        check_eq("i_c2_iwait", 32'(bus.iwait), 32'd1); tick();
        bus.ramstate = RS_ACCESS; bus.ramload = 32'hCAFE0040;
        probe(); check_eq("i_c3_ren", 32'(bus.ramREN), 32'd1);
        check_eq("i_c3_iwait", 32'(bus.iwait), 32'd0);
        check_eq("i_c3_dwait", 32'(bus.dwait), 32'd1);
        check_eq("i_c3_iload", bus.iload, 32'hCAFE0040); tick();
        bus.iREN = 1'b0; bus.ramstate = RS_FREE;
        probe(); check_eq("i_c4_ren", 32'(bus.ramREN), 32'd0);
        check_eq("i_c4_iwait", 32'(bus.iwait), 32'd1); tick();
        idle(1);

        // simultaneous dcache write and icache read: dcache first
        bus.iREN = 1'b1; bus.iaddr = 32'h44;
        bus.dWEN = 1'b1; bus.daddr = 32'h3100; bus.dstore = 32'hDEADBEEF;
        probe(); tick();
        bus.ramstate = RS_ACCESS;
        probe();
        check_eq("dw_wen",   32'(bus.ramWEN), 32'd1);
        check_eq("dw_ren",   32'(bus.ramREN), 32'd0);
        check_eq("dw_addr",  bus.ramaddr,     32'h3100);
        check_eq("dw_store", bus.ramstore,    32'hDEADBEEF);
        check_eq("dw_dwait", 32'(bus.dwait),  32'd0);
        check_eq("dw_iwait", 32'(bus.iwait),  32'd1);
        tick();
        bus.dWEN = 1'b0; bus.ramstate = RS_FREE;
        probe(); check_eq("dw_idle_ren", 32'(bus.ramREN), 32'd0); tick();
        bus.ramstate = RS_ACCESS;
        probe();
        check_eq("dw_then_i_ren",  32'(bus.ramREN), 32'd1);
        check_eq("dw_then_i_addr", bus.ramaddr,     32'h44);
        check_eq("dw_then_i_wait", 32'(bus.iwait),  32'd0);
        tick();
        idle(2);

        // back-to-back dcache reads with an ifetch waiting throughout
        bus.iREN = 1'b1; bus.iaddr = 32'h80;
        for (int k = 0; k < 6; k++) begin
            bus.dREN = 1'b1; bus.daddr = 32'h1000 + 32'(k * 4); bus.ramstate = RS_FREE;
            probe(); tick();
            bus.ramstate = RS_ACCESS;
            probe();
            exp_addr = (FAIR && k == 4) ? 32'h80 : bus.daddr;
            check_eq($sformatf("fair_slot%0d_addr", k), bus.ramaddr, exp_addr);
            check_eq($sformatf("fair_slot%0d_iwait", k), 32'(bus.iwait),
                     (FAIR && k == 4) ? 32'd0 : 32'd1);
            tick();
        end
        idle(2);

        // read and write together, ERROR first then retry
        bus.dREN = 1'b1; bus.dWEN = 1'b1; bus.daddr = 32'h2222; bus.dstore = 32'h12345678;
        probe(); tick();
        bus.ramstate = RS_ERROR;
        probe();
        check_eq("rw_wen",     32'(bus.ramWEN), 32'd1);
        check_eq("rw_ren",     32'(bus.ramREN), 32'd0);
        check_eq("errr_dwait", 32'(bus.dwait),  32'd1);
        tick();
        bus.ramstate = RS_FREE;
        probe();
        check_eq("errr_err",  32'(bus.err),    32'd1);
        check_eq("errr_idle", 32'(bus.ramWEN), 32'd0);
        tick();
        bus.ramstate = RS_ACCESS;
        probe();
        check_eq("retry_wen",   32'(bus.ramWEN), 32'd1);
        check_eq("retry_dwait", 32'(bus.dwait),  32'd0);
        check_eq("retry_err",   32'(bus.err),    32'd1);
        tick();
        idle(1);

        // dcache drops its read mid-grant, then an ifetch proves the arbiter is idle
        bus.dREN = 1'b1; bus.daddr = 32'h3000;
        probe(); tick();
        bus.ramstate = RS_BUSY;
        probe(); check_eq("drop_c1_ren", 32'(bus.ramREN), 32'd1); tick();
        bus.dREN = 1'b0;
        probe();
        check_eq("drop_c2_ren",   32'(bus.ramREN), 32'd0);
        check_eq("drop_c2_dwait", 32'(bus.dwait),  32'd1);
        tick();
        bus.iREN = 1'b1; bus.iaddr = 32'h9C; bus.ramstate = RS_ACCESS;
        probe();
        check_eq("drop_c3_ren",   32'(bus.ramREN), 32'd0);
        check_eq("drop_c3_dwait", 32'(bus.dwait),  32'd1);
        tick();
        probe(); check_eq("drop_c4_iaddr", bus.ramaddr, 32'h9C); tick();
        idle(1);

        // reset pulse in the middle of a grant clears strobes and err at once
        bus.dREN = 1'b1; bus.daddr = 32'h4000;
        probe(); tick();
        bus.ramstate = RS_BUSY;
        probe(); check_eq("rmid_ren_before", 32'(bus.ramREN), 32'd1);
        nRST = 1'b0;
        #1;
        check_eq("rmid_ren",   32'(bus.ramREN), 32'd0);
        check_eq("rmid_addr",  bus.ramaddr,     32'd0);
        check_eq("rmid_dwait", 32'(bus.dwait),  32'd1);
        check_eq("rmid_err",   32'(bus.err),    32'd0);
        model_reset();
        bus.dREN = 1'b0; bus.ramstate = RS_FREE;
        #1 nRST = 1'b1;
        @(negedge CLK);
        idle(2);

        // randomized traffic: caches hold requests until served, occasionally abandon them
        for (int c = 0; c < 1500; c++) begin
            if ((bus.dREN | bus.dWEN) && exp_dwait && $urandom_range(99) >= 3) begin
                // keep the pending dcache request stable
            end else if ($urandom_range(99) < 55) begin
                ops = $urandom_range(2);
                bus.dREN = (ops != 1); bus.dWEN = (ops != 0);
                bus.daddr = $urandom; bus.dstore = $urandom;
            end else begin
                bus.dREN = 1'b0; bus.dWEN = 1'b0;
            end
            if (bus.iREN && exp_iwait && $urandom_range(99) >= 3) begin
                // keep the pending ifetch stable
            end else if ($urandom_range(99) < 60) begin
                bus.iREN = 1'b1; bus.iaddr = $urandom;
            end else begin
                bus.iREN = 1'b0;
            end
            bus.ramstate = pick_ramstate();
            bus.ramload  = $urandom;
            probe();
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
